// File: rtl/sseg_pkg.sv
// Shared definitions for the 7-segment digit scanner: FSM encoding, BCD limit,
// and the counter-width helper.
package sseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Bits needed to hold max(a,b)-1, never less than one.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sseg_slot_timer.sv
// Loadable down-counter: after a load of N-1 it reports done in the N-th cycle.
// Shared by the lit (SHOW) and dead-time (DEAD) intervals.
module sseg_slot_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         done
);

  logic [W-1:0] cnt_r;

  // Count down to zero and park there until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= len;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == '0);

endmodule

// File: rtl/sseg_digit_scanner.sv
// Time-multiplexed scan controller feeding a BCD-to-7-segment decoder, with dead time,
// tear-free frame loading, leading-zero suppression and blanking of non-BCD codes.
module sseg_digit_scanner
  import sseg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DIV         = 50000,
  parameter int BLANK_CYC   = 16,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [3:0]            bcd_out,
  output logic                  blank,
  output logic [DIGITS-1:0]     dig_en_n,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_W = cnt_width(DIV, BLANK_CYC);
  localparam logic [CNT_W-1:0] SHOW_LEN = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LEN = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t              state_r, nxt_state_s;
  logic [IDX_W-1:0]    idx_r, nxt_idx_s, wrap_idx_s;
  logic [4*DIGITS-1:0] active_r, pending_r, nxt_active_s, nxt_pending_s;
  logic                pend_vld_r, nxt_pend_vld_s;
  logic                tload_s, tdone_s, enter0_s;
  logic [CNT_W-1:0]    tlen_s;
  logic [DIGITS-1:0]   lz_s, nxt_dig_en_n_s;
  logic [3:0]          digit_s, nxt_bcd_out_s;
  logic                nxt_blank_s;

  function automatic logic [3:0] digit_at(input logic [4*DIGITS-1:0] v,
                                          input logic [IDX_W-1:0] i);
    return v[{i, 2'b00} +: 4];
  endfunction

  // Digit i (i>0) is a leading zero when it and every more significant digit are zero.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] v);
    logic all_zero;
    logic [DIGITS-1:0] m;
    all_zero = 1'b1;
    m = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (v[4*i +: 4] == 4'd0);
      m[i] = (LZ_SUPPRESS != 0) && all_zero;
    end
    return m;
  endfunction

  sseg_slot_timer #(.W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tload_s),
    .len   (tlen_s),
    .done  (tdone_s)
  );

  assign wrap_idx_s = (idx_r == LAST_IDX) ? '0 : idx_r + 1'b1;

  // Next-state logic; the timer is reloaded on every state entry.
  always_comb begin
    nxt_state_s = state_r;
    nxt_idx_s   = idx_r;
    tload_s     = 1'b0;
    tlen_s      = SHOW_LEN;
    enter0_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        nxt_idx_s = '0;
        if (en) begin
          nxt_state_s = ST_SHOW;
          tload_s     = 1'b1;
          enter0_s    = 1'b1;
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (!en) begin
          nxt_state_s = ST_IDLE;
          nxt_idx_s   = '0;
        end else if (tdone_s) begin
          nxt_state_s = ST_DEAD;
          tload_s     = 1'b1;
          tlen_s      = DEAD_LEN;
        end else begin
          nxt_state_s = ST_SHOW;
        end
      end
      ST_DEAD: begin
        if (!en) begin
          nxt_state_s = ST_IDLE;
          nxt_idx_s   = '0;
        end else if (tdone_s) begin
          nxt_state_s = ST_SHOW;
          nxt_idx_s   = wrap_idx_s;
          tload_s     = 1'b1;
          enter0_s    = (wrap_idx_s == '0);
        end else begin
          nxt_state_s = ST_DEAD;
        end
      end
      default: begin
        nxt_state_s = ST_IDLE;
        nxt_idx_s   = '0;
      end
    endcase
  end

  // Display value only changes at a frame start (or while idle), so a frame never tears.
  always_comb begin
    nxt_active_s   = active_r;
    nxt_pending_s  = pending_r;
    nxt_pend_vld_s = pend_vld_r;
    if (load && (enter0_s || state_r == ST_IDLE)) begin
      nxt_active_s   = bcd_in;
      nxt_pend_vld_s = 1'b0;
    end else if (load) begin
      nxt_pending_s  = bcd_in;
      nxt_pend_vld_s = 1'b1;
    end else if (enter0_s && pend_vld_r) begin
      nxt_active_s   = pending_r;
      nxt_pend_vld_s = 1'b0;
    end else begin
      nxt_active_s   = active_r;
    end
  end

  assign lz_s    = lz_mask(nxt_active_s);
  assign digit_s = digit_at(nxt_active_s, nxt_idx_s);

  // Output values are derived from next-state data so they can be registered.
  always_comb begin
    nxt_dig_en_n_s = '1;
    nxt_blank_s    = 1'b1;
    nxt_bcd_out_s  = bcd_out;
    if (nxt_state_s == ST_SHOW) begin
      nxt_bcd_out_s  = digit_s;
      nxt_blank_s    = lz_s[nxt_idx_s] | (digit_s > BCD_MAX);
      nxt_dig_en_n_s = lz_s[nxt_idx_s] ? '1 : ~(DIGITS'(1) << nxt_idx_s);
    end else begin
      nxt_dig_en_n_s = '1;
    end
  end

  // FSM state, display data and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= '0;
      active_r   <= '0;
      pending_r  <= '0;
      pend_vld_r <= 1'b0;
      bcd_out    <= 4'd0;
      blank      <= 1'b1;
      dig_en_n   <= '1;
      frame_done <= 1'b0;
    end else begin
      state_r    <= nxt_state_s;
      idx_r      <= nxt_idx_s;
      active_r   <= nxt_active_s;
      pending_r  <= nxt_pending_s;
      pend_vld_r <= nxt_pend_vld_s;
      bcd_out    <= nxt_bcd_out_s;
      blank      <= nxt_blank_s;
      dig_en_n   <= nxt_dig_en_n_s;
      frame_done <= enter0_s;
    end
  end

endmodule

// File: tb/tb_sseg_digit_scanner.sv
// Directed bench for sseg_digit_scanner with DIGITS=4, DIV=4, BLANK_CYC=2, LZ_SUPPRESS=1.
module tb_sseg_digit_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bcd_in = 16'h0000;
  logic [3:0]  bcd_out;
  logic        blank;
  logic [3:0]  dig_en_n;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;

  sseg_digit_scanner #(
    .DIGITS(4), .DIV(4), .BLANK_CYC(2), .LZ_SUPPRESS(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .bcd_in     (bcd_in),
    .bcd_out    (bcd_out),
    .blank      (blank),
    .dig_en_n   (dig_en_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one 24-cycle frame starting at its first lit cycle; optionally pulses load.
  task automatic check_frame(input logic [15:0] val, input logic do_load, input int load_cyc,
                             input logic [15:0] load_val, input string tag);
    logic [9:0] got, exp;
    logic [3:0] dig;
    logic       sup;
    for (int s = 0; s < 4; s++) begin
      dig = 4'(val >> (4 * s));
      sup = (s != 0) && ((val >> (4 * s)) == 16'h0000);
      for (int k = 0; k < 6; k++) begin
        if (k < 4)
          exp = {sup ? 4'hF : ~(4'b0001 << s), sup | (dig > 4'd9), dig, (s == 0 && k == 0)};
        else
          exp = {4'hF, 1'b1, dig, 1'b0};
        got = {dig_en_n, blank, bcd_out, frame_done};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL %s slot %0d cyc %0d: {en_n,blank,bcd,fd} got %b required %b",
                   tag, s, k, got, exp);
        end
        if (do_load && (s * 6 + k) == load_cyc) begin
          load = 1'b1;
          bcd_in = load_val;
        end else begin
          load = 1'b0;
        end
        tick();
      end
    end
  endtask

  task automatic test_reset();
    logic [9:0] got;
    rst_n = 1'b0;
    en = 1'b0;
    tick();
    got = {dig_en_n, blank, bcd_out, frame_done};
    vectors++;
    if (got !== {4'hF, 1'b1, 4'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_held: got %b required %b", got, {4'hF, 1'b1, 4'h0, 1'b0});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      got = {dig_en_n, blank, bcd_out, frame_done};
      vectors++;
      if (got !== {4'hF, 1'b1, 4'h0, 1'b0}) begin
        miscompares++;
        $display("FAIL idle_dark cyc %0d: got %b required %b", i, got, {4'hF, 1'b1, 4'h0, 1'b0});
      end
    end
  endtask

  task automatic test_scan();
    load = 1'b1;
    bcd_in = 16'h1234;
    tick();
    load = 1'b0;
    en = 1'b1;
    tick();
    check_frame(16'h1234, 1'b0, 0, 16'h0, "scan_f0");
    check_frame(16'h1234, 1'b0, 0, 16'h0, "scan_f1");
  endtask

  task automatic test_load_lz_invalid();
    check_frame(16'h1234, 1'b1, 5, 16'h0007, "old_until_wrap");
    check_frame(16'h0007, 1'b1, 23, 16'h0000, "lz_0007");
    check_frame(16'h0000, 1'b1, 12, 16'h0A05, "zero_shows_0");
    check_frame(16'h0A05, 1'b1, 23, 16'h1234, "invalid_0a05");
    check_frame(16'h1234, 1'b0, 0, 16'h0, "wrap_edge_load");
  endtask

  task automatic test_en_drop_and_reset();
    logic [9:0] got;
    for (int c = 0; c < 16; c++) begin
      load = (c == 3);
      bcd_in = 16'h0042;
      tick();
    end
    load = 1'b0;
    got = {dig_en_n, blank, bcd_out, frame_done};
    vectors++;
    if (got !== {4'hF, 1'b1, 4'h2, 1'b0}) begin
      miscompares++;
      $display("FAIL dead_d2: got %b required %b", got, {4'hF, 1'b1, 4'h2, 1'b0});
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({dig_en_n, blank, frame_done} !== 6'b1111_1_0) begin
        miscompares++;
        $display("FAIL en_drop_dark cyc %0d: got %b required %b", i,
                 {dig_en_n, blank, frame_done}, 6'b1111_1_0);
      end
    end
    en = 1'b1;
    tick();
    check_frame(16'h0042, 1'b0, 0, 16'h0, "restart_pending");
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    got = {dig_en_n, blank, bcd_out, frame_done};
    vectors++;
    if (got !== {4'hF, 1'b1, 4'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: got %b required %b", got, {4'hF, 1'b1, 4'h0, 1'b0});
    end
    #1;
    rst_n = 1'b1;
    tick();
    check_frame(16'h0000, 1'b0, 0, 16'h0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [3:0] prev_en;
    int         run;
    logic       first;
    prev_en = 4'hF;
    run = 0;
    first = 1'b1;
    load = 1'b1;
    bcd_in = 16'h8888;
    for (int c = 0; c < 240; c++) begin
      vectors++;
      if ($countones(~dig_en_n) > 1) begin
        miscompares++;
        $display("FAIL onehot cyc %0d: dig_en_n %b required at most one low", c, dig_en_n);
      end
      if (dig_en_n == 4'hF) begin
        run++;
      end else begin
        if (dig_en_n != prev_en) begin
          if (!first) begin
            vectors++;
            if (run < 2) begin
              miscompares++;
              $display("FAIL dead_gap cyc %0d: gap %0d required >= 2", c, run);
            end
          end
          first = 1'b0;
        end
        run = 0;
      end
      prev_en = dig_en_n;
      tick();
      load = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_lz_invalid();
    test_en_drop_and_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
